// File: rtl/dram_req_arb.sv
// dram_req_arb: arbitrates lenet read/write requests onto one single-port DRAM.
// Writes are posted into a small FIFO; reads that hit a queued write take the
// newest queued data instead of going to DRAM. Read data returns in order,
// two cycles after acceptance.
module dram_req_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int WQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    input  logic                  en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    output logic                  req_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int              PTR_W    = $clog2(WQ_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(WQ_DEPTH);

    logic [ADDR_WIDTH-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_WIDTH-1:0] wq_data [WQ_DEPTH];
    logic [PTR_W-1:0]      wq_head;
    logic [PTR_W-1:0]      wq_tail;
    logic [PTR_W:0]        wq_count;

    logic                  wq_full;
    logic                  wq_empty;
    logic                  acc_rd;
    logic                  acc_wr;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      fwd_idx;
    logic                  rd_miss;
    logic                  drain;

    logic                  vld_p0;
    logic                  vld_p1;
    logic                  fwd_p0;
    logic                  fwd_p1;
    logic [DATA_WIDTH-1:0] fdata_p0;
    logic [DATA_WIDTH-1:0] fdata_p1;

    // Acceptance depends only on the count register, so lenet sees a stable
    // ready for the whole cycle.
    assign wq_full   = (wq_count == FULL_CNT);
    assign wq_empty  = (wq_count == '0);
    assign req_ready = ~wq_full;
    assign acc_rd    = en_rd & req_ready;
    assign acc_wr    = en_wr & req_ready;

    // Search queued writes oldest-to-newest so the newest matching entry wins;
    // the same-cycle write is not yet in the FIFO, so the read is ordered first.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            fwd_idx = wq_head + PTR_W'(i);
            if (((PTR_W+1)'(i) < wq_count) && (wq_addr[fwd_idx] == addr_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = wq_data[fwd_idx];
            end
        end
    end

    // Port arbitration: full FIFO drains first, then read misses, then drain.
    always_comb begin
        rd_miss = acc_rd & ~fwd_hit;
        drain   = 1'b0;
        if (wq_full) begin
            drain = 1'b1;
        end else if (rd_miss) begin
            drain = 1'b0;
        end else if (!wq_empty) begin
            drain = 1'b1;
        end
    end

    // FIFO pointers and occupancy; push and drain together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq_head  <= '0;
            wq_tail  <= '0;
            wq_count <= '0;
        end else begin
            if (acc_wr) begin
                wq_tail <= wq_tail + 1'b1;
            end
            if (drain) begin
                wq_head <= wq_head + 1'b1;
            end
            wq_count <= wq_count + (PTR_W+1)'(acc_wr) - (PTR_W+1)'(drain);
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            wq_addr[wq_tail] <= addr_wr;
            wq_data[wq_tail] <= data_wr;
        end
    end

    // Registered DRAM port; address/data hold when idle to avoid toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= drain | rd_miss;
            mem_we <= drain;
            if (drain) begin
                mem_addr  <= wq_addr[wq_head];
                mem_wdata <= wq_data[wq_head];
            end else if (rd_miss) begin
                mem_addr <= addr_rd;
            end
        end
    end

    // Response control: p0 at acceptance, p1 while DRAM returns data, then output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            fwd_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            fwd_p1   <= 1'b0;
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            vld_p0 <= acc_rd;
            fwd_p0 <= fwd_hit;
            vld_p1 <= vld_p0;
            fwd_p1 <= fwd_p0;
            valid  <= vld_p1;
            if (vld_p1) begin
                data_out <= fwd_p1 ? fdata_p1 : mem_rdata;
            end
        end
    end

    // Forwarded data travels alongside its valid; qualified by vld_pN, no reset.
    always_ff @(posedge clk) begin
        fdata_p0 <= fwd_data;
        fdata_p1 <= fdata_p0;
    end

endmodule

// File: tb/tb_dram_req_arb.sv
// Testbench for dram_req_arb with a behavioural single-port DRAM and an
// in-order response scoreboard.
module tb_dram_req_arb;

    localparam int DW  = 32;
    localparam int AW  = 18;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en_rd = 1'b0;
    logic [AW-1:0] addr_rd = '0;
    logic          en_wr = 1'b0;
    logic [AW-1:0] addr_wr = '0;
    logic [DW-1:0] data_wr = '0;
    logic          req_ready;
    logic          valid;
    logic [DW-1:0] data_out;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dram_req_arb #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WQ_DEPTH   (DEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_rd     (en_rd),
        .addr_rd   (addr_rd),
        .en_wr     (en_wr),
        .addr_wr   (addr_wr),
        .data_wr   (data_wr),
        .req_ready (req_ready),
        .valid     (valid),
        .data_out  (data_out),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] dram    [0:63];
    logic [31:0] ref_mem [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port DRAM: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dram[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= dram[mem_addr[5:0]];
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp_missing: no valid, expected %h due cycle %0d (now %0d)",
                             sb[0].data, sb[0].due, cyc);
                    void'(sb.pop_front());
                end
                if (valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL resp_unexpected: valid with data %h, none expected (cycle %0d)",
                                 data_out, cyc);
                    end else begin
                        e = sb.pop_front();
                        check32("resp_data", data_out, e.data);
                        check32("resp_latency", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic drive(input bit rd, input int ra, input bit wr, input int wa,
                         input logic [31:0] wd, input bit hand, input logic [31:0] hexp,
                         output bit acc);
        exp_t e;
        @(negedge clk);
        en_rd   = rd;
        addr_rd = AW'(ra);
        en_wr   = wr;
        addr_wr = AW'(wa);
        data_wr = wd;
        #1;
        acc = req_ready;
        if (acc && rd) begin
            e.data = hand ? hexp : ref_mem[ra[5:0]];
            e.due  = cyc + 3;
            sb.push_back(e);
        end
        if (acc && wr) ref_mem[wa[5:0]] = wd;
        @(posedge clk);
        #1;
        en_rd = 1'b0;
        en_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        bit          rd, wr;
        int          ra, wa;
        logic [31:0] wd;
        logic [31:0] wq_wd [4];
        int          wq_wa [4];

        for (int i = 0; i < 64; i++) begin
            dram[i]    <= 32'hC0DE_0000 | 32'(i);
            ref_mem[i]  = 32'hC0DE_0000 | 32'(i);
        end
        dram[16'h10]    <= 32'hDEADBEEF;
        ref_mem[16'h10]  = 32'hDEADBEEF;
        dram[16'h20]    <= 32'hAAAAAAAA;
        ref_mem[16'h20]  = 32'hAAAAAAAA;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check32("rst_valid",     32'(valid),     0);
        check32("rst_data_out",  data_out,       0);
        check32("rst_mem_en",    32'(mem_en),    0);
        check32("rst_mem_we",    32'(mem_we),    0);
        check32("rst_mem_addr",  32'(mem_addr),  0);
        check32("rst_mem_wdata", mem_wdata,      0);
        check32("rst_req_ready", 32'(req_ready), 1);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Plain read
        drive(1, 'h10, 0, 0, 0, 1, 32'hDEADBEEF, acc);
        check32("plain_acc",      32'(acc),      1);
        check32("plain_mem_en",   32'(mem_en),   1);
        check32("plain_mem_we",   32'(mem_we),   0);
        check32("plain_mem_addr", 32'(mem_addr), 'h10);

        // Reset in the middle of in-flight reads
        drive(1, 1, 0, 0, 0, 1, 32'hC0DE0001, acc);
        drive(1, 2, 0, 0, 0, 1, 32'hC0DE0002, acc);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check32("midrst_valid",     32'(valid),     0);
        check32("midrst_data_out",  data_out,       0);
        check32("midrst_mem_en",    32'(mem_en),    0);
        check32("midrst_req_ready", 32'(req_ready), 1);
        idle(2);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check32("postrst_valid", 32'(valid), 0);
        end

        // Forwarding from the newest queued write
        drive(1, 5, 1, 'h10, 32'h11111111, 1, 32'hC0DE0005, acc);
        drive(1, 6, 1, 'h10, 32'h22222222, 1, 32'hC0DE0006, acc);
        drive(1, 'h10, 0, 0, 0, 1, 32'h22222222, acc);
        check32("fwd_acc",          32'(acc),              1);
        check32("fwd_no_dram_read", 32'(mem_en & ~mem_we), 0);
        check32("fwd_drain_we",     32'(mem_we),           1);
        check32("fwd_drain_addr",   32'(mem_addr),         'h10);
        check32("fwd_drain_data",   mem_wdata,             32'h11111111);

        // Same-cycle read and write: the read sees the old value
        idle(4);
        drive(1, 'h20, 1, 'h20, 32'hBBBBBBBB, 1, 32'hAAAAAAAA, acc);
        check32("same_mem_en",   32'(mem_en),   1);
        check32("same_mem_we",   32'(mem_we),   0);
        check32("same_mem_addr", 32'(mem_addr), 'h20);
        idle(2);
        drive(1, 'h20, 0, 0, 0, 1, 32'hBBBBBBBB, acc);

        // Fill the FIFO while read misses hold the port
        idle(4);
        wq_wa[0] = 'h30; wq_wd[0] = 32'hA1A1A1A1;
        wq_wa[1] = 'h31; wq_wd[1] = 32'hA2A2A2A2;
        wq_wa[2] = 'h30; wq_wd[2] = 32'hA3A3A3A3;
        wq_wa[3] = 'h32; wq_wd[3] = 32'hA4A4A4A4;
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 1, wq_wa[i], wq_wd[i], 1, 32'hC0DE0000 | 32'(i), acc);
            check32("full_fill_acc", 32'(acc), 1);
        end
        check32("full_req_ready", 32'(req_ready), 0);
        drive(1, 4, 0, 0, 0, 1, 32'hC0DE0004, acc);
        check32("full_reject",        32'(acc),       0);
        check32("full_drain_en",      32'(mem_en),    1);
        check32("full_drain_we",      32'(mem_we),    1);
        check32("full_drain_addr",    32'(mem_addr),  'h30);
        check32("full_drain_data",    mem_wdata,      32'hA1A1A1A1);
        check32("full_ready_again",   32'(req_ready), 1);
        drive(1, 4, 0, 0, 0, 1, 32'hC0DE0004, acc);
        check32("full_retry_acc", 32'(acc), 1);
        idle(8);
        check32("full_dram_30", dram['h30], 32'hA3A3A3A3);
        check32("full_dram_31", dram['h31], 32'hA2A2A2A2);
        check32("full_dram_32", dram['h32], 32'hA4A4A4A4);

        // Mixed random stream over 16 addresses; rejected requests are held
        acc = 1'b1;
        rd = 0; wr = 0; ra = 0; wa = 0; wd = '0;
        for (int n = 0; n < 1000; n++) begin
            if (acc) begin
                rd = ($urandom_range(0, 9) < 6);
                wr = ($urandom_range(0, 9) < 5);
                ra = int'($urandom_range(0, 15));
                wa = int'($urandom_range(0, 15));
                wd = $urandom;
            end
            drive(rd, ra, wr, wa, wd, 0, 0, acc);
        end

        begin
            int budget;
            budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            idle(2);
            check32("sb_drained", 32'(sb.size()), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dram_req_arb.md
# dram_req_arb

Single-port DRAM request arbiter between the `lenet` accelerator and a single-port DRAM macro. It accepts `lenet`'s independent read and write requests, queues writes in a small posted-write FIFO, and issues at most one access per cycle on the shared port. Reads that hit a queued write are served by store-to-load forwarding, so `lenet` always reads the newest value. Read data returns in request order with a fixed latency.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 18, word address width
- `WQ_DEPTH`, 4, posted-write FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en_rd`  in  1  read request from `lenet`
- `addr_rd`  in  ADDR_WIDTH  read address
- `en_wr`  in  1  write request from `lenet`
- `addr_wr`  in  ADDR_WIDTH  write address
- `data_wr`  in  DATA_WIDTH  write data
- `req_ready`  out  1  requests accepted this cycle when high
- `valid`  out  1  read response strobe
- `data_out`  out  DATA_WIDTH  read response data
- `mem_en`  out  1  DRAM access strobe
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_WIDTH  DRAM address
- `mem_wdata`  out  DATA_WIDTH  DRAM write data
- `mem_rdata`  in  DATA_WIDTH  DRAM read data, valid the cycle after a read strobe

## Operation
- `req_ready = (wq_count != WQ_DEPTH)`; combinational from the count register only.
- A request is accepted when its enable and `req_ready` are high at a rising edge. `lenet` holds a rejected request.
- Accepted write: pushed to the FIFO tail.
- Accepted read, forwarding check: compare `addr_rd` against all FIFO entries present before this edge.
  - Hit: take data from the newest matching entry. No DRAM access.
  - Miss: issue a DRAM read.
- A same-cycle write is never visible to the same-cycle read: the read is ordered before the write.
- Port arbitration per cycle, in this priority:
  1. FIFO full: drain the head to DRAM. No read is accepted, because `req_ready` is 0.
  2. Accepted read that misses: DRAM read.
  3. FIFO non-empty: drain the head.
  4. Otherwise: `mem_en` = 0.
- Push and drain on the same edge leave `wq_count` unchanged. Count never exceeds `WQ_DEPTH` and never underflows.
- Response pipeline: 2 stages. Each stage carries valid, fwd flag, and fwd data. Stage 2 selects `mem_rdata` when fwd = 0. Responses stay strictly in order.
- FIFO pointers: `log2(WQ_DEPTH)` bits, wrapping naturally.

## Timing
- `mem_*` outputs are registered. A decision made at edge k drives `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` during cycle k to k+1.
- Read accepted at edge k: `valid` = 1 and `data_out` is correct from edge k+2 to edge k+3, exactly one cycle. This holds for both forwarded and DRAM-sourced reads.
- Back-to-back reads: one response per cycle, with no bubbles unless the FIFO is full.
- Write accepted at edge k: it can reach DRAM at the earliest at edge k+1 (drain), and only if no read miss wins that cycle.
- Reset values (asynchronous): `valid` = 0, `data_out` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, FIFO empty, `req_ready` = 1.
- Reset asserted mid-operation discards queued writes and in-flight responses. `valid` stays 0 until a new read is accepted after release.

## Test plan
- Reset check: assert `rst` asynchronously between edges. All outputs clear immediately. After release, `req_ready` = 1.
- Plain read: DRAM[0x00010] = 0xDEADBEEF. Read at edge k → `mem_en` = 1, `mem_we` = 0, `mem_addr` = 0x00010 in cycle k, then `valid` = 1, `data_out` = 0xDEADBEEF at k+2.
- Forwarding: write 0x10 = 0x11111111, then write 0x10 = 0x22222222, then read 0x10 before either drains → `data_out` = 0x22222222 and no DRAM read strobe.
- Same-cycle read and write to 0x20, where DRAM[0x20] = 0xAAAAAAAA: write 0xBBBBBBBB while reading → read returns 0xAAAAAAAA. A later read returns 0xBBBBBBBB.
- FIFO full: 4 writes, each followed by a read-miss stream that blocks draining → `req_ready` = 0. The next cycle drains the head, then `req_ready` = 1. Final DRAM contents match the writes in order.
- Mixed stream: 1000 random reads and writes over 16 addresses against a reference memory model → every `valid` matches the model, in order, with exact 2-cycle latency.
